// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Purpose  : Per-bit two-flop synchronizer plus stability counter for bouncing
//            slide switches; SW_clean is flop-driven and safe as a latch gate.
//            Optional macro SW_EDGE_PULSE_EN adds registered SW_rise/SW_fall.
// Revision : 1.0
// ============================================================================
module switch_debouncer #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 500000,
  parameter int CNT_W   = 19
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] SW_raw,
  output logic [WIDTH-1:0] SW_clean,
  output logic [WIDTH-1:0] SW_rise,
  output logic [WIDTH-1:0] SW_fall
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_clean_nxt;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SW_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_expire;

    assign w_differ = r_sync2[i] ^ SW_clean[i];
    // The >= compare keeps the counter bounded even from an unexpected value.
    assign w_expire = w_differ && (r_cnt >= C_CNT_LAST);
    assign w_clean_nxt[i] = w_expire ? r_sync2[i] : SW_clean[i];

    always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
        r_cnt <= '0;
      end else if (!w_differ || w_expire) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      SW_clean <= '0;
    end else begin
      SW_clean <= w_clean_nxt;
    end
  end

`ifdef SW_EDGE_PULSE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_clean_nxt & ~SW_clean;
      r_fall <= ~w_clean_nxt & SW_clean;
    end
  end

  assign SW_rise = r_rise;
  assign SW_fall = r_fall;
`else
  assign SW_rise = '0;
  assign SW_fall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debouncer
// Purpose  : Directed and randomized checks of switch_debouncer against a
//            sliding-window model (WIDTH=2, CNT_MAX=4, CNT_W=3).
// Revision : 1.0
// ============================================================================
module tb_switch_debouncer;
  localparam int W  = 2;
  localparam int CM = 4;
  localparam int CW = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw   = '0;
  logic [W-1:0] clean;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(W), .CNT_MAX(CM), .CNT_W(CW)) dut (
    .Clk     (clk),
    .Resetn  (rst_n),
    .SW_raw  (raw),
    .SW_clean(clean),
    .SW_rise (rise),
    .SW_fall (fall)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pe(input logic [W-1:0] v);
`ifdef SW_EDGE_PULSE_EN
    return v;
`else
    return '0;
`endif
  endfunction

  // Model: s2 is raw delayed by two edges; a bit flips once the last CM values
  // seen at s2 all disagree with the current clean level.
  logic [W-1:0] m_clean = '0;
  logic [W-1:0] m_rise  = '0;
  logic [W-1:0] m_fall  = '0;
  logic [W-1:0] dly[$];
  logic [W-1:0] seen_q[$];

  initial begin
    logic [W-1:0] seen;
    dly = '{2'b00, 2'b00};
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        dly     = '{2'b00, 2'b00};
        seen_q.delete();
      end else begin
        seen = dly.pop_front();
        dly.push_back(raw);
        seen_q.push_back(seen);
        if (seen_q.size() > CM) void'(seen_q.pop_front());
        m_rise = '0;
        m_fall = '0;
        for (int b = 0; b < W; b++) begin
          int agree;
          agree = 0;
          foreach (seen_q[k]) if (seen_q[k][b] == m_clean[b]) agree++;
          if (seen_q.size() == CM && agree == 0) begin
            if (m_clean[b]) m_fall[b] = 1'b1;
            else            m_rise[b] = 1'b1;
            m_clean[b] = ~m_clean[b];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_clean", clean, m_clean);
      check("model_rise", rise, pe(m_rise));
      check("model_fall", fall, pe(m_fall));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with switches high, then release.
    raw   = 2'b11;
    rst_n = 1'b0;
    edges(10);
    check("t1_reset_clean", clean, 2'b00);
    check("t1_reset_rise", rise, 2'b00);
    check("t1_reset_fall", fall, 2'b00);
    rst_n = 1'b1;
    edges(5);
    check("t1_not_early", clean, 2'b00);
    edges(1);
    check("t1_sixth_edge", clean, 2'b11);

    // Single bit rising, exact latency.
    raw   = 2'b00;
    rst_n = 1'b0;
    #3;
    check("t2_async_clear", clean, 2'b00);
    edges(1);
    rst_n = 1'b1;
    edges(3);
    raw = 2'b01;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      check($sformatf("t2_hold_e%0d", k), clean, 2'b00);
    end
    edges(1);
    check("t2_edge5", clean, 2'b01);

    // Bouncing input: short levels are rejected, final level lands on edge 5.
    raw = 2'b00;
    edges(8);
    check("t3_start", clean, 2'b00);
    raw = 2'b01; edges(2);
    raw = 2'b00; edges(2);
    raw = 2'b01; edges(2);
    raw = 2'b00; edges(2);
    raw = 2'b01;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      check($sformatf("t3_hold_e%0d", k), clean, 2'b00);
    end
    edges(1);
    check("t3_edge5", clean, 2'b01);

    // Short pulse on bit 1 never appears.
    raw = 2'b11; edges(3);
    raw = 2'b01; edges(10);
    check("t4_short_pulse", clean, 2'b01);

    // Both bits together, with edge pulses.
    raw = 2'b00;
    edges(8);
    check("t5_start", clean, 2'b00);
    raw = 2'b11;
    edges(5);
    check("t5_not_early", clean, 2'b00);
    edges(1);
    check("t5_rise_clean", clean, 2'b11);
    check("t5_rise_pulse", rise, pe(2'b11));
    check("t5_no_fall", fall, 2'b00);
    edges(1);
    check("t5_rise_one_cycle", rise, 2'b00);
    edges(3);
    raw = 2'b00;
    edges(6);
    check("t5_fall_clean", clean, 2'b00);
    check("t5_fall_pulse", fall, pe(2'b11));
    check("t5_no_rise", rise, 2'b00);
    edges(1);
    check("t5_fall_one_cycle", fall, 2'b00);

    // Reset in the middle of a count.
    raw = 2'b10;
    edges(8);
    check("t6_start", clean, 2'b10);
    raw = 2'b11;
    edges(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", clean, 2'b00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    edges(5);
    check("t6_not_early", clean, 2'b00);
    edges(1);
    check("t6_sixth_edge", clean, 2'b11);

    // Randomized bouncing with occasional asynchronous resets.
    for (int r = 0; r < 400; r++) begin
      raw = W'($urandom_range(0, 3));
      repeat ($urandom_range(1, 8)) @(posedge clk);
      #1;
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    edges(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
